// File: rtl/branch_predictor_pkg.sv
// Shared counter encodings for the branch direction predictor.
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    BP_SNT = 2'b00,
    BP_WNT = 2'b01,
    BP_WT  = 2'b10,
    BP_ST  = 2'b11
  } bp_cnt_e;

  localparam bp_cnt_e BP_RST_CNT = BP_WNT;

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// 2-bit saturating counter next-state function: taken counts up, not-taken down.
module sat_counter
  import branch_predictor_pkg::*;
(
  input  bp_cnt_e cnt_i,
  input  logic    taken_i,
  output bp_cnt_e cnt_o
);

  always_comb begin
    cnt_o = cnt_i;
    unique case (cnt_i)
      BP_SNT: cnt_o = taken_i ? BP_WNT : BP_SNT;
      BP_WNT: cnt_o = taken_i ? BP_WT  : BP_SNT;
      BP_WT:  cnt_o = taken_i ? BP_ST  : BP_WNT;
      BP_ST:  cnt_o = taken_i ? BP_ST  : BP_WT;
      default: cnt_o = cnt_i;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Table of 2-bit direction counters indexed by pc[IDX+1:2], trained from execute.
// Define BP_TAGGED_EN to add per-entry valid/tag and allocate-on-miss.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int LINES  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] pc_guess,
  input  logic              is_br_guess,
  output logic              br_taken_guess,
  input  logic [AWIDTH-1:0] pc_check,
  input  logic              is_br_check,
  input  logic              br_taken_check,
  output logic              br_mispred
);

  localparam int IDX = $clog2(LINES);

  logic [IDX-1:0] guess_idx, check_idx;
  bp_cnt_e        cnt_q [LINES];
  bp_cnt_e        trained_cnt, cnt_d;
  logic           guess_hit, check_hit, check_dir;
  logic           mispred_d, mispred_q;
  logic           unused_pc_bits;

  assign guess_idx = pc_guess[IDX+1:2];
  assign check_idx = pc_check[IDX+1:2];

  sat_counter u_sat (
    .cnt_i  (cnt_q[check_idx]),
    .taken_i(br_taken_check),
    .cnt_o  (trained_cnt)
  );

`ifdef BP_TAGGED_EN
  localparam int TW = AWIDTH - IDX - 2;

  logic [TW-1:0]    tag_q [LINES];
  logic [LINES-1:0] valid_q;

  assign guess_hit = valid_q[guess_idx] && (tag_q[guess_idx] == pc_guess[AWIDTH-1:IDX+2]);
  assign check_hit = valid_q[check_idx] && (tag_q[check_idx] == pc_check[AWIDTH-1:IDX+2]);
  assign unused_pc_bits = ^{pc_guess[1:0], pc_check[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (is_br_check && !check_hit) begin
      valid_q[check_idx] <= 1'b1;
      tag_q[check_idx]   <= pc_check[AWIDTH-1:IDX+2];
    end
  end

  // A fresh allocation starts one step from neutral toward the observed outcome.
  assign cnt_d = check_hit ? trained_cnt : (br_taken_check ? BP_WT : BP_WNT);
`else
  assign guess_hit = 1'b1;
  assign check_hit = 1'b1;
  assign cnt_d     = trained_cnt;
  assign unused_pc_bits = ^{pc_guess[1:0], pc_guess[AWIDTH-1:IDX+2],
                            pc_check[1:0], pc_check[AWIDTH-1:IDX+2]};
`endif

  assign check_dir = check_hit && cnt_q[check_idx][1];
  assign mispred_d = is_br_check && (check_dir != br_taken_check);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LINES; i++) cnt_q[i] <= BP_RST_CNT;
      mispred_q <= 1'b0;
    end else begin
      mispred_q <= mispred_d;
      if (is_br_check) cnt_q[check_idx] <= cnt_d;
    end
  end

  // No bypass: a same-cycle update is only seen by the next guess.
  assign br_taken_guess = is_br_guess && guess_hit && cnt_q[guess_idx][1];
  assign br_mispred     = mispred_q;

endmodule
